regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-read-port register file with two write ports and
// per-register reservation ("pending") bits for scoreboarding.
//
// Register 0 is hardwired to zero and can never be reserved. Reads are
// combinational. Write port 1 wins when both ports write the same address.
// A reservation and a write to the same address in one cycle leaves the
// register pending; the new producer wins.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports (port 1 priority over port 0).
//
// Ports:
//   clk                   clock, rising edge
//   rst                   asynchronous reset, active low
//   raddr   [NREAD*AW]    read addresses, port k at [k*AW +: AW]
//   rdata   [NREAD*XLEN]  read data, port k at [k*XLEN +: XLEN]
//   rbusy   [NREAD]       pending flag of the register read on port k
//   we0/waddr0/wdata0     write port 0
//   we1/waddr1/wdata1     write port 1
//   rsv_en/rsv_addr       reservation request
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned NREAD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wdata1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr
);

    logic [XLEN-1:0] r_regs    [NREGS];
    logic [NREGS-1:0] r_pending;

    // Entry 0 is only ever cleared by reset, so it stays zero for good.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (we1 && (waddr1 == AW'(i))) begin
                    r_regs[i] <= wdata1;
                end else if (we0 && (waddr0 == AW'(i))) begin
                    r_regs[i] <= wdata0;
                end

                // Set beats clear: a fresh reservation outlives a retiring write.
                if (rsv_en && (rsv_addr == AW'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if ((we0 && (waddr0 == AW'(i))) || (we1 && (waddr1 == AW'(i)))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = raddr[k*AW +: AW];

        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = r_pending[w_addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarded data is by definition produced, so the register is busy
            // only if a new reservation targets it in this same cycle.
            if (we0 && (waddr0 == w_addr)) begin
                w_data = wdata0;
                w_busy = rsv_en && (rsv_addr == w_addr);
            end
            if (we1 && (waddr1 == w_addr)) begin
                w_data = wdata1;
                w_busy = rsv_en && (rsv_addr == w_addr);
            end
`endif
            // Address 0 and reset both force zeros (also covers the bypass path).
            if (!rst || (w_addr == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rdata[k*XLEN +: XLEN] = w_data;
        assign rbusy[k]              = w_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (XLEN=32, NREGS=64,
// NREAD=2). A table of directed vectors is applied one per cycle: inputs are
// driven after the falling edge, outputs checked shortly after, and the
// rising edge then commits the writes/reservations of that row. Reset
// behaviour is covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned NREAD = 2;

    logic                  clk;
    logic                  rst;
    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  we0;
    logic [AW-1:0]         waddr0;
    logic [XLEN-1:0]       wdata0;
    logic                  we1;
    logic [AW-1:0]         waddr1;
    logic [XLEN-1:0]       wdata1;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;

    regfile_mp #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .AW   (AW),
        .NREAD(NREAD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raddr   (raddr),
        .rdata   (rdata),
        .rbusy   (rbusy),
        .we0     (we0),
        .waddr0  (waddr0),
        .wdata0  (wdata0),
        .we1     (we1),
        .waddr1  (waddr1),
        .wdata1  (wdata1),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [5:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [5:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [5:0]  ra;
        logic [5:0]  rd0;
        logic [5:0]  rd1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(logic w0, logic [5:0] a0, logic [31:0] d0,
                                logic w1, logic [5:0] a1, logic [31:0] d1,
                                logic rv, logic [5:0] ra, logic [5:0] r0, logic [5:0] r1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.rsv = rv; v.ra = ra; v.rd0 = r0; v.rd1 = r1;
        v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic set_read(input logic [5:0] a0, input logic [5:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic check_reads(input string name, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [1:0] eb);
        check32({name, " rdata0"}, rdata[31:0], e0);
        check32({name, " rdata1"}, rdata[63:32], e1);
        check2({name, " rbusy"}, rbusy, eb);
    endtask

    initial begin
        logic [31:0] bypass_exp;
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 32'ha5a5a5a5;
`else
        bypass_exp = 32'h0;
`endif
        //                 we0 wa0  wd0            we1 wa1  wd1            rsv ra  rd0 rd1 e0            e1            eb
        vecs[0]  = mk(1, 1, 32'hdeadbeef, 0, 0, 32'h0,        0, 0, 2, 3, 32'h0,        32'h0,        2'b00);
        vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 32'hdeadbeef, 32'hdeadbeef, 2'b00);
        vecs[2]  = mk(1, 0, 32'h12345678, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'hdeadbeef, 2'b00);
        vecs[3]  = mk(1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00);
        vecs[4]  = mk(1, 6, 32'haaaa0006, 1, 7, 32'hbbbb0007, 0, 0, 5, 0, 32'h22222222, 32'h0,        2'b00);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 6, 7, 32'haaaa0006, 32'hbbbb0007, 2'b00);
        vecs[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 3, 32'h0,        32'h0,        2'b11);
        vecs[7]  = mk(0, 0, 32'h0,        1, 3, 32'hcafef00d, 0, 0, 5, 6, 32'h22222222, 32'haaaa0006, 2'b00);
        vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 7, 32'hcafef00d, 32'hbbbb0007, 2'b00);
        vecs[9]  = mk(1, 3, 32'h0badf00d, 0, 0, 32'h0,        1, 3, 2, 1, 32'h0,        32'hdeadbeef, 2'b00);
        vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 3, 32'h0badf00d, 32'h0badf00d, 2'b11);
        vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 0, 0, 32'h0,        32'h0,        2'b00);
        vecs[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 3, 0, 32'h0badf00d, 32'h0,        2'b01);
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 3, 32'h0,        32'h0badf00d, 2'b10);
        vecs[14] = mk(1, 9, 32'ha5a5a5a5, 0, 0, 32'h0,        0, 0, 9, 9, bypass_exp,   bypass_exp,   2'b00);
        vecs[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 9, 1, 32'ha5a5a5a5, 32'hdeadbeef, 2'b00);

        // Reset, with a write attempted while held low.
        rst = 1'b0;
        idle();
        set_read(6'd0, 6'd0);
        @(negedge clk);
        we0 = 1'b1; waddr0 = 6'd8; wdata0 = 32'h88888888;
        @(negedge clk);
        idle();
        rst = 1'b1;

        // Every address on both ports reads zero and not busy after reset.
        for (int a = 0; a < int'(NREGS); a++) begin
            set_read(6'(a), 6'(NREGS - 1 - a));
            #1;
            check_reads($sformatf("reset addr %0d", a), 32'h0, 32'h0, 2'b00);
        end

        // Directed table: check before the edge, commit at the edge.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
            we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
            rsv_en = vecs[i].rsv; rsv_addr = vecs[i].ra;
            set_read(vecs[i].rd0, vecs[i].rd1);
            #1;
            check_reads($sformatf("vec %0d", i), vecs[i].e0, vecs[i].e1, vecs[i].eb);
        end

        // Load regs 1..4, reserve reg 2.
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            idle();
            we0 = 1'b1; waddr0 = 6'(r); wdata0 = 32'h100 + 32'(r);
        end
        @(negedge clk);
        idle();
        rsv_en = 1'b1; rsv_addr = 6'd2;
        @(negedge clk);
        idle();
        set_read(6'd2, 6'd4);
        #1;
        check_reads("loaded", 32'h102, 32'h104, 2'b01);

        // Mid-cycle async reset while a write to reg 4 is presented.
        we0 = 1'b1; waddr0 = 6'd4; wdata0 = 32'hffffffff;
        #1;
        rst = 1'b0;
        #1;
        check_reads("async rst", 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        check_reads("rst held", 32'h0, 32'h0, 2'b00);
        idle();
        rst = 1'b1;
        for (int r = 1; r <= 4; r += 2) begin
            set_read(6'(r), 6'(r + 1));
            #1;
            check_reads($sformatf("post rst %0d", r), 32'h0, 32'h0, 2'b00);
        end

        // First cycle after release: write must take effect.
        we1 = 1'b1; waddr1 = 6'd10; wdata1 = 32'h00000077;
        set_read(6'd8, 6'd4);
        #1;
        check_reads("release cycle", 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        idle();
        set_read(6'd10, 6'd2);
        #1;
        check_reads("write after release", 32'h00000077, 32'h0, 2'b00);
        @(negedge clk);
        set_read(6'd4, 6'd3);
        #1;
        check_reads("still cleared", 32'h0, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
